// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dds_sweep_ctrl
//  Purpose  : Frequency-sweep sequencer feeding the DDS core frequency word;
//             single, repeating sawtooth and continuous triangle sweeps.
//  Revision : 1.0  initial release
// ============================================================================
module dds_sweep_ctrl #(
    parameter int FW = 23,
    parameter int DW = 24
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    output logic [FW-1:0] freq_word,
    output logic          freq_valid,
    output logic          busy,
    output logic          done,
    output logic          dir
);

    localparam logic [DW-1:0] c_one = DW'(1);
    localparam logic [DW-1:0] c_two = DW'(2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_cnt, w_cnt_nxt;
    logic [DW-1:0] r_dwell, w_dwell_in;
    logic [FW-1:0] r_word, w_word_nxt;
    logic [FW-1:0] r_f_start, r_f_stop, r_f_step;
    logic [1:0]    r_mode;
    logic          r_valid, w_valid_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_dir, w_dir_nxt;
    logic          w_load;

    logic [FW:0]   w_up_sum, w_dn_floor;
    logic [FW-1:0] w_up_word, w_dn_word;
    logic          w_degen, w_at_stop, w_at_start;
    logic          w_saw, w_tri, w_single;

    // Step arithmetic carries one extra bit so the sum never wraps before the clamp.
    assign w_up_sum   = {1'b0, r_word} + {1'b0, r_f_step};
    assign w_up_word  = (w_up_sum >= {1'b0, r_f_stop}) ? r_f_stop : w_up_sum[FW-1:0];
    assign w_dn_floor = {1'b0, r_f_start} + {1'b0, r_f_step};
    assign w_dn_word  = ({1'b0, r_word} <= w_dn_floor) ? r_f_start : (r_word - r_f_step);

    assign w_degen    = (r_f_step == '0) || (r_f_start >= r_f_stop);
    assign w_at_stop  = (r_word == r_f_stop);
    assign w_at_start = (r_word == r_f_start);
    assign w_saw      = (r_mode == 2'b01);
    assign w_tri      = (r_mode == 2'b10);
    assign w_single   = !w_saw && !w_tri;
    assign w_dwell_in = (dwell == '0) ? c_one : dwell;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = r_busy;
        w_dir_nxt   = r_dir;
        w_load      = 1'b0;

        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_load      = 1'b1;
                        w_word_nxt  = f_start;
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_dir_nxt   = 1'b1;
                        w_cnt_nxt   = w_dwell_in;
                        w_state_nxt = (w_dwell_in == c_one) ? ST_STEP : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    w_cnt_nxt = r_cnt - c_one;
                    if (r_cnt <= c_two) begin
                        w_state_nxt = ST_STEP;
                    end
                end
                ST_STEP: begin
                    // Last cycle of the dwell: the new word lands on the next edge.
                    w_cnt_nxt   = r_dwell;
                    w_state_nxt = (r_dwell == c_one) ? ST_STEP : ST_HOLD;
                    if (w_single && (w_degen || w_at_stop)) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else if (!w_degen) begin
                        if (w_tri && !r_dir) begin
                            if (w_at_start) begin
                                w_dir_nxt  = 1'b1;
                                w_word_nxt = w_up_word;
                            end else begin
                                w_word_nxt = w_dn_word;
                            end
                        end else if (w_at_stop) begin
                            if (w_tri) begin
                                w_dir_nxt  = 1'b0;
                                w_word_nxt = w_dn_word;
                            end else begin
                                w_word_nxt = r_f_start;
                            end
                        end else begin
                            w_word_nxt = w_up_word;
                        end
                        w_valid_nxt = (w_word_nxt != r_word);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dir     <= 1'b1;
            r_dwell   <= '0;
            r_f_start <= '0;
            r_f_stop  <= '0;
            r_f_step  <= '0;
            r_mode    <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_dir   <= w_dir_nxt;
            if (w_load) begin
                r_dwell   <= w_dwell_in;
                r_f_start <= f_start;
                r_f_stop  <= f_stop;
                r_f_step  <= f_step;
                r_mode    <= mode;
            end
        end
    end

    assign freq_word  = r_word;
    assign freq_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign dir        = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_sweep_ctrl
//  Purpose  : Self-checking bench for dds_sweep_ctrl (directed table,
//             hand-written corner sequences, randomized sweeps vs. model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dds_sweep_ctrl;

    localparam int FW = 23;
    localparam int DW = 24;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          start;
    logic          abort;
    logic [1:0]    mode;
    logic [FW-1:0] f_start, f_stop, f_step;
    logic [DW-1:0] dwell;
    logic [FW-1:0] freq_word;
    logic          freq_valid, busy, done, dir;

    int checks   = 0;
    int failures = 0;

    dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_step     (f_step),
        .dwell      (dwell),
        .freq_word  (freq_word),
        .freq_valid (freq_valid),
        .busy       (busy),
        .done       (done),
        .dir        (dir)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [1:0]       md;
        logic [22:0]      fs, fe, fp;
        logic [23:0]      dw;
        logic             dn;
        logic [3:0]       len;
        logic [7:0][22:0] words;
        logic [7:0]       dirs;
    } vec_t;

    vec_t tbl [7];

    // Reference sweep: the sequence of distinct dwell slots, one entry per slot.
    int q_w[$];
    bit q_d[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic launch(input int md, input int fs, input int fe, input int fp, input int dw);
        mode    = 2'(md);
        f_start = FW'(fs);
        f_stop  = FW'(fe);
        f_step  = FW'(fp);
        dwell   = DW'(dw);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic idle_out();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic add_vec(input int idx, input int md, input int fs, input int fe, input int fp,
                           input int dw, input bit dn, input int len,
                           input int w0, input int w1, input int w2, input int w3,
                           input int w4, input int w5, input int w6, input int w7,
                           input logic [7:0] dirs);
        vec_t v;
        v.md = 2'(md); v.fs = 23'(fs); v.fe = 23'(fe); v.fp = 23'(fp);
        v.dw = 24'(dw); v.dn = dn; v.len = 4'(len); v.dirs = dirs;
        v.words[0] = 23'(w0); v.words[1] = 23'(w1); v.words[2] = 23'(w2); v.words[3] = 23'(w3);
        v.words[4] = 23'(w4); v.words[5] = 23'(w5); v.words[6] = 23'(w6); v.words[7] = 23'(w7);
        tbl[idx] = v;
    endtask

    task automatic build(input int md, input int fs, input int fe, input int fp, input int need);
        int  up_q[$];
        int  dn_q[$];
        int  w;
        bit  single;
        single = (md == 0) || (md == 3);
        q_w.delete();
        q_d.delete();
        if (fp == 0 || fs >= fe) begin
            q_w.push_back(fs); q_d.push_back(1'b1);
            if (!single)
                while (q_w.size() < need) begin q_w.push_back(fs); q_d.push_back(1'b1); end
            return;
        end
        w = fs; up_q.push_back(w);
        while (w != fe) begin w = (w + fp >= fe) ? fe : w + fp; up_q.push_back(w); end
        w = fe; dn_q.push_back(w);
        while (w != fs) begin w = (w <= fs + fp) ? fs : w - fp; dn_q.push_back(w); end
        foreach (up_q[i]) begin q_w.push_back(up_q[i]); q_d.push_back(1'b1); end
        if (single) return;
        while (q_w.size() < need) begin
            if (md == 1) begin
                foreach (up_q[i]) begin q_w.push_back(up_q[i]); q_d.push_back(1'b1); end
            end else begin
                for (int i = 1; i < dn_q.size(); i++) begin q_w.push_back(dn_q[i]); q_d.push_back(1'b0); end
                for (int i = 1; i < up_q.size(); i++) begin q_w.push_back(up_q[i]); q_d.push_back(1'b1); end
            end
        end
    endtask

    initial begin
        vec_t v;
        int   deff, idx, t_done, tlen, md, fs, fe, fp, dw;
        bit   single, ev;

        sys_rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00;
        f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
        repeat (3) tick();
        sys_rst = 1'b0;
        chk("reset word", 32'(freq_word), 0);
        chk("reset valid", 32'(freq_valid), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset dir", 32'(dir), 1);

        // ---------------- directed table ----------------
        add_vec(0, 0, 100, 130, 10, 3, 1, 4, 100, 110, 120, 130, 0, 0, 0, 0, 8'hFF);
        add_vec(1, 0, 100, 125, 10, 1, 1, 4, 100, 110, 120, 125, 0, 0, 0, 0, 8'hFF);
        add_vec(2, 2, 0, 10, 5, 1, 0, 7, 0, 5, 10, 5, 0, 5, 10, 0, 8'b0110_0111);
        add_vec(3, 1, 0, 10, 5, 0, 0, 6, 0, 5, 10, 0, 5, 10, 0, 0, 8'hFF);
        add_vec(4, 3, 0, 20, 10, 2, 1, 3, 0, 10, 20, 0, 0, 0, 0, 0, 8'hFF);
        add_vec(5, 0, 50, 60, 0, 2, 1, 1, 50, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add_vec(6, 1, 70, 70, 5, 1, 0, 1, 70, 0, 0, 0, 0, 0, 0, 0, 8'hFF);

        for (int i = 0; i < 7; i++) begin
            v = tbl[i];
            deff = (v.dw == 0) ? 1 : int'(v.dw);
            launch(int'(v.md), int'(v.fs), int'(v.fe), int'(v.fp), int'(v.dw));
            for (int t = 1; t <= int'(v.len) * deff; t++) begin
                idx = (t - 1) / deff;
                chk($sformatf("vec%0d word t%0d", i, t), 32'(freq_word), 32'(v.words[idx]));
                chk($sformatf("vec%0d valid t%0d", i, t), 32'(freq_valid), ((t - 1) % deff == 0) ? 1 : 0);
                chk($sformatf("vec%0d busy t%0d", i, t), 32'(busy), 1);
                chk($sformatf("vec%0d dir t%0d", i, t), 32'(dir), 32'(v.dirs[idx]));
                chk($sformatf("vec%0d done t%0d", i, t), 32'(done), 0);
                tick();
            end
            if (v.dn) begin
                chk($sformatf("vec%0d end done", i), 32'(done), 1);
                chk($sformatf("vec%0d end busy", i), 32'(busy), 0);
                chk($sformatf("vec%0d end valid", i), 32'(freq_valid), 0);
                chk($sformatf("vec%0d end word", i), 32'(freq_word), 32'(v.words[v.len - 1]));
                tick();
                chk($sformatf("vec%0d after done", i), 32'(done), 0);
                chk($sformatf("vec%0d after word", i), 32'(freq_word), 32'(v.words[v.len - 1]));
            end else begin
                chk($sformatf("vec%0d cont busy", i), 32'(busy), 1);
                chk($sformatf("vec%0d cont done", i), 32'(done), 0);
            end
            idle_out();
            chk($sformatf("vec%0d abort busy", i), 32'(busy), 0);
        end

        // ---------------- abort with an ignored mid-sweep start ----------------
        launch(0, 100, 200, 10, 4);
        for (int t = 1; t <= 13; t++) begin
            chk($sformatf("abt word t%0d", t), 32'(freq_word), 32'(100 + 10 * ((t - 1) / 4)));
            chk($sformatf("abt busy t%0d", t), 32'(busy), 1);
            start = (t == 3);
            abort = (t == 13);
            tick();
        end
        start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("abt post busy", 32'(busy), 0);
            chk("abt post word", 32'(freq_word), 130);
            chk("abt post done", 32'(done), 0);
            chk("abt post valid", 32'(freq_valid), 0);
            tick();
        end
        launch(0, 100, 200, 10, 4);
        chk("restart word", 32'(freq_word), 100);
        chk("restart valid", 32'(freq_valid), 1);
        chk("restart busy", 32'(busy), 1);
        idle_out();

        // ---------------- reset mid-sweep (triangle on its way down) ----------------
        launch(2, 100, 130, 10, 1);
        for (int t = 1; t <= 5; t++) begin
            chk($sformatf("rst word t%0d", t), 32'(freq_word), (t <= 4) ? 32'(90 + 10 * t) : 120);
            if (t < 5) tick();
        end
        chk("rst pre dir", 32'(dir), 0);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("rst word", 32'(freq_word), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst dir", 32'(dir), 1);
        chk("rst valid", 32'(freq_valid), 0);

        // ---------------- start and abort together ----------------
        mode = 2'b00; f_start = 23'd40; f_stop = 23'd90; f_step = 23'd5; dwell = 24'd1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa busy", 32'(busy), 0);
        chk("sa valid", 32'(freq_valid), 0);
        chk("sa word", 32'(freq_word), 0);
        tick();
        chk("sa busy later", 32'(busy), 0);

        // ---------------- randomized sweeps vs. reference model ----------------
        for (int trial = 0; trial < 30; trial++) begin
            md = int'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                fe = 8388607 - int'($urandom_range(0, 30));
                fs = fe - int'($urandom_range(0, 150));
                fp = int'($urandom_range(1, 200));
            end else begin
                fs = int'($urandom_range(0, 60));
                fe = int'($urandom_range(0, 80));
                fp = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 25));
            end
            dw     = int'($urandom_range(0, 3));
            deff   = (dw == 0) ? 1 : dw;
            single = (md == 0) || (md == 3);
            build(md, fs, fe, fp, 60 / deff + 3);
            t_done = q_w.size() * deff + 1;
            tlen   = single ? t_done + 2 : 60;
            launch(md, fs, fe, fp, dw);
            for (int t = 1; t <= tlen; t++) begin
                if (single && t >= t_done) begin
                    chk($sformatf("rnd%0d word t%0d", trial, t), 32'(freq_word), 32'(q_w[q_w.size() - 1]));
                    chk($sformatf("rnd%0d valid t%0d", trial, t), 32'(freq_valid), 0);
                    chk($sformatf("rnd%0d busy t%0d", trial, t), 32'(busy), 0);
                    chk($sformatf("rnd%0d done t%0d", trial, t), 32'(done), (t == t_done) ? 1 : 0);
                    chk($sformatf("rnd%0d dir t%0d", trial, t), 32'(dir), 1);
                end else begin
                    idx = (t - 1) / deff;
                    ev  = ((t - 1) % deff == 0) && (idx == 0 || q_w[idx] != q_w[idx - 1]);
                    chk($sformatf("rnd%0d word t%0d", trial, t), 32'(freq_word), 32'(q_w[idx]));
                    chk($sformatf("rnd%0d valid t%0d", trial, t), 32'(freq_valid), 32'(ev));
                    chk($sformatf("rnd%0d busy t%0d", trial, t), 32'(busy), 1);
                    chk($sformatf("rnd%0d done t%0d", trial, t), 32'(done), 0);
                    chk($sformatf("rnd%0d dir t%0d", trial, t), 32'(dir), 32'(q_d[idx]));
                end
                mode    = 2'($urandom_range(0, 3));
                f_start = FW'($urandom);
                f_stop  = FW'($urandom);
                f_step  = FW'($urandom_range(0, 50));
                dwell   = DW'($urandom_range(0, 5));
                start   = (!single || t < t_done - 1) ? ($urandom_range(0, 9) == 0) : 1'b0;
                tick();
            end
            idle_out();
            chk($sformatf("rnd%0d abort busy", trial), 32'(busy), 0);
            chk($sformatf("rnd%0d abort valid", trial), 32'(freq_valid), 0);
            chk($sformatf("rnd%0d abort done", trial), 32'(done), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
